// File: rtl/gpio_bus_arbiter.sv
// gpio_bus_arbiter: round-robin arbiter that shares one GPIO/UART peripheral port between two bus masters.
// One transaction at a time, with address-window decode, fixed-latency read capture and per-master ack/err.
`default_nettype none

module gpio_bus_arbiter #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter int unsigned PER_LAT   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_ack,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_ack,
    output logic [31:0] rdata,
    output logic        err,
    output logic        p_en,
    output logic        p_store,
    output logic        p_load,
    output logic [31:0] p_addr,
    output logic [31:0] p_wdata,
    input  logic [31:0] p_rdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [2:0] LAT = 3'(PER_LAT);

    state_t      state_q;
    logic        owner_q;
    logic        last_q;
    logic        we_q;
    logic        bad_q;
    logic [2:0]  cnt_q;
    logic        m0_gnt_q, m1_gnt_q, m0_ack_q, m1_ack_q, err_q;
    logic        p_en_q, p_store_q, p_load_q;
    logic [31:0] p_addr_q, p_wdata_q, rdata_q;

    logic        owner_d;
    logic        we_d;
    logic [31:0] addr_d;
    logic [31:0] wdata_d;
    logic        in_win_d;

    // On a tie the master that did not finish the previous transaction wins.
    always_comb begin
        owner_d = m1_req;
        if (m0_req && m1_req) begin
            owner_d = ~last_q;
        end
        we_d     = owner_d ? m1_we    : m0_we;
        addr_d   = owner_d ? m1_addr  : m0_addr;
        wdata_d  = owner_d ? m1_wdata : m0_wdata;
        in_win_d = (addr_d[31:4] == BASE_ADDR[31:4]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            we_q      <= 1'b0;
            bad_q     <= 1'b0;
            cnt_q     <= 3'd0;
            m0_gnt_q  <= 1'b0;
            m1_gnt_q  <= 1'b0;
            m0_ack_q  <= 1'b0;
            m1_ack_q  <= 1'b0;
            err_q     <= 1'b0;
            p_en_q    <= 1'b0;
            p_store_q <= 1'b0;
            p_load_q  <= 1'b0;
            p_addr_q  <= 32'd0;
            p_wdata_q <= 32'd0;
            rdata_q   <= 32'd0;
        end else begin
            m0_gnt_q  <= 1'b0;
            m1_gnt_q  <= 1'b0;
            m0_ack_q  <= 1'b0;
            m1_ack_q  <= 1'b0;
            err_q     <= 1'b0;
            p_en_q    <= 1'b0;
            p_store_q <= 1'b0;
            p_load_q  <= 1'b0;
            p_addr_q  <= 32'd0;
            p_wdata_q <= 32'd0;
            case (state_q)
                S_IDLE: begin
                    if (m0_req || m1_req) begin
                        owner_q  <= owner_d;
                        we_q     <= we_d;
                        bad_q    <= ~in_win_d;
                        m0_gnt_q <= ~owner_d;
                        m1_gnt_q <= owner_d;
                        if (in_win_d) begin
                            p_en_q    <= 1'b1;
                            p_store_q <= we_d;
                            p_load_q  <= ~we_d;
                            p_addr_q  <= addr_d;
                            p_wdata_q <= wdata_d;
                        end
                        state_q <= S_ISSUE;
                    end
                end
                // An out-of-window request passes through here with p_en held low
                // and is acked straight away, two cycles after the request.
                S_ISSUE: begin
                    if (bad_q) begin
                        m0_ack_q <= ~owner_q;
                        m1_ack_q <= owner_q;
                        err_q    <= 1'b1;
                        state_q  <= S_RESP;
                    end else begin
                        cnt_q   <= LAT;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q <= 3'd1) begin
                        if (!we_q) begin
                            rdata_q <= p_rdata;
                        end
                        m0_ack_q <= ~owner_q;
                        m1_ack_q <= owner_q;
                        state_q  <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                S_RESP: begin
                    last_q  <= owner_q;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign m0_gnt  = m0_gnt_q;
    assign m1_gnt  = m1_gnt_q;
    assign m0_ack  = m0_ack_q;
    assign m1_ack  = m1_ack_q;
    assign err     = err_q;
    assign p_en    = p_en_q;
    assign p_store = p_store_q;
    assign p_load  = p_load_q;
    assign p_addr  = p_addr_q;
    assign p_wdata = p_wdata_q;
    assign rdata   = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_gpio_bus_arbiter.sv
// tb_gpio_bus_arbiter: directed self-checking bench for gpio_bus_arbiter.
// Two instances (PER_LAT=1 and PER_LAT=3) share the same stimulus.
`default_nettype none

module tb_gpio_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, p_rdata;

    logic        a_m0_gnt, a_m0_ack, a_m1_gnt, a_m1_ack, a_err, a_p_en, a_p_store, a_p_load;
    logic [31:0] a_rdata, a_p_addr, a_p_wdata;
    logic        b_m0_gnt, b_m0_ack, b_m1_gnt, b_m1_ack, b_err, b_p_en, b_p_store, b_p_load;
    logic [31:0] b_rdata, b_p_addr, b_p_wdata;

    int n_chk = 0;
    int n_bad = 0;
    int n;

    always #5 clk = ~clk;

    gpio_bus_arbiter #(.BASE_ADDR(32'h0000_1000), .PER_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(a_m0_gnt), .m0_ack(a_m0_ack),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(a_m1_gnt), .m1_ack(a_m1_ack),
        .rdata(a_rdata), .err(a_err),
        .p_en(a_p_en), .p_store(a_p_store), .p_load(a_p_load),
        .p_addr(a_p_addr), .p_wdata(a_p_wdata), .p_rdata(p_rdata)
    );

    gpio_bus_arbiter #(.BASE_ADDR(32'h0000_1000), .PER_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(b_m0_gnt), .m0_ack(b_m0_ack),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(b_m1_gnt), .m1_ack(b_m1_ack),
        .rdata(b_rdata), .err(b_err),
        .p_en(b_p_en), .p_store(b_p_store), .p_load(b_p_load),
        .p_addr(b_p_addr), .p_wdata(b_p_wdata), .p_rdata(p_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'd0; m0_wdata = 32'd0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'd0; m1_wdata = 32'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        p_rdata = 32'd0;
        do_reset();
        chk("rst_gnt", {a_m0_gnt, a_m1_gnt, b_m0_gnt, b_m1_gnt}, 0);
        chk("rst_ack", {a_m0_ack, a_m1_ack, a_err, a_p_en}, 0);
        chk("rst_rdata", a_rdata, 0);

        // 1: M0 store in window
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h1002; m0_wdata = 32'h1;
        step();
        chk("t1_gnt", {a_m0_gnt, a_m1_gnt}, 2'b10);
        chk("t1_pen", {a_p_en, a_p_store, a_p_load}, 3'b110);
        chk("t1_paddr", a_p_addr, 32'h1002);
        chk("t1_pwdata", a_p_wdata, 32'h1);
        step();
        chk("t1_mid", {a_m0_ack, a_m0_gnt, a_p_en}, 0);
        step();
        chk("t1_ack", {a_m0_ack, a_m1_ack, a_err}, 3'b100);
        chk("t1_rdata", a_rdata, 0);
        @(negedge clk); m0_req = 1'b0;
        step();
        chk("t1_ackoff", a_m0_ack, 0);

        // 2: M1 load; only the sample-cycle p_rdata may be captured
        @(negedge clk);
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h1006; p_rdata = 32'hDEAD_BEEF;
        step();
        chk("t2_gnt", {a_m0_gnt, a_m1_gnt}, 2'b01);
        chk("t2_pen", {a_p_en, a_p_store, a_p_load}, 3'b101);
        chk("t2_paddr", a_p_addr, 32'h1006);
        step();
        @(negedge clk); p_rdata = 32'h1;
        step();
        chk("t2_ack", {a_m0_ack, a_m1_ack, a_err}, 3'b010);
        chk("t2_rdata", a_rdata, 32'h1);
        @(negedge clk); m1_req = 1'b0; p_rdata = 32'h0000_BAD0;
        step(); step();
        chk("t2_hold", a_rdata, 32'h1);

        // 3: both masters continuously requesting from reset
        do_reset();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h1000;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h1004;
        p_rdata = 32'h55;
        for (int i = 0; i < 6; i++) begin
            n = 0;
            do begin step(); n++; end while (!(a_m0_gnt | a_m1_gnt) && n < 12);
            chk("t3_found", {31'd0, a_m0_gnt | a_m1_gnt}, 1);
            chk("t3_owner", {a_m0_gnt, a_m1_gnt}, (i % 2 == 0) ? 2'b10 : 2'b01);
        end
        @(negedge clk); m0_req = 1'b0; m1_req = 1'b0;
        repeat (6) step();
        chk("t3_rdata", a_rdata, 32'h55);

        // 4: out-of-window load, then a store just past the window top
        @(negedge clk);
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h2000; p_rdata = 32'h77;
        step();
        chk("t4_gnt", {a_m0_gnt, a_p_en}, 2'b10);
        step();
        chk("t4_ack", {a_m0_ack, a_m1_ack, a_err, a_p_en}, 4'b1010);
        chk("t4_rdata", a_rdata, 32'h55);
        @(negedge clk); m0_req = 1'b0;
        step();
        @(negedge clk);
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h1010;
        step();
        chk("t4b_gnt", {a_m1_gnt, a_p_en}, 2'b10);
        step();
        chk("t4b_ack", {a_m1_ack, a_err}, 2'b11);
        @(negedge clk); m1_req = 1'b0;
        step();
        chk("t4b_erroff", {a_err, a_m1_ack}, 0);

        // 5: PER_LAT=3 instance, top address of the window
        do_reset();
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h100F; p_rdata = 32'hA0;
        step();
        chk("t5_gnt", {b_m1_gnt, b_p_en, b_p_load}, 3'b111);
        chk("t5_paddr", b_p_addr, 32'h100F);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk); p_rdata = 32'hA0 + k;
            step();
            if (k < 4) chk("t5_early", b_m1_ack, 0);
            else begin
                chk("t5_ack", {b_m1_ack, b_err}, 2'b10);
                chk("t5_rdata", b_rdata, 32'hA4);
            end
        end
        @(negedge clk); m1_req = 1'b0;
        step(); step();

        // 6: reset while the PER_LAT=3 instance is in WAIT
        @(negedge clk);
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h1000; p_rdata = 32'h66;
        step(); step();
        @(negedge clk); rst_n = 1'b0;
        #1;
        chk("t6_rdata", b_rdata, 0);
        chk("t6_rdata1", a_rdata, 0);
        chk("t6_outs", {b_m0_gnt, b_m0_ack, b_p_en, b_err, a_m0_ack, a_p_en}, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t6_noack", {b_m0_ack, a_m0_ack}, 0);
        end
        @(negedge clk); rst_n = 1'b1;
        n = 0;
        while (!b_m0_gnt && n < 8) begin step(); n++; end
        chk("t6_gnt", {31'd0, b_m0_gnt}, 1);
        chk("t6_paddr", b_p_addr, 32'h1000);
        n = 0;
        do begin step(); n++; end while (!b_m0_ack && n < 10);
        chk("t6_lat", n, 4);
        chk("t6_rd", b_rdata, 32'h66);
        @(negedge clk); m0_req = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
